kernel_sequencer: RTL and testbench

- Sequences the ALU kernel path over an image held in byte-wide synchronous RAM.
- For each 3x3 window it fetches the pixels and packs them into the 3x24-bit cache rows, then drives kernelsel and captures the ALU result. It writes that result to an output buffer.
- Sits between the memory stage and the ALU's kernel input: software issues one start per image pass and waits for done.

---
 rtl/kernel_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_kernel_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_sequencer.sv
// Fetches each valid 3x3 window of a byte image, packs it into three 24-bit cache rows,
// captures the ALU result and writes it out. Define KSEQ_SLIDE_REUSE_EN for column reuse.
module kernel_sequencer #(
   parameter int bus    = 8,
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int ADDR_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            kernelsel_in,
   input  logic [ADDR_W-1:0]     src_base,
   input  logic [ADDR_W-1:0]     dst_base,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [7:0]            rd_data,
   output logic [2:0][23:0]      cache,
   output logic [1:0]            kernelsel,
   input  logic [bus-1:0]        alu_result,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [bus-1:0]        wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [2:0]            state_dbg
);

   // Handshake: start is a single-cycle request honoured only in IDLE; rd_data is
   // expected exactly one cycle after rd_en; wr_en is a one-cycle write strobe.

`ifdef KSEQ_SLIDE_REUSE_EN
   localparam bit REUSE_EN = 1'b1;
`else
   localparam bit REUSE_EN = 1'b0;
`endif

   localparam logic [7:0] X_LAST = 8'(IMG_W - 2);
   localparam logic [7:0] Y_LAST = 8'(IMG_H - 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_DRAIN = 3'd2,
      S_EXEC  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            x_q, x_d;
   logic [7:0]            y_q, y_d;
   logic [1:0]            rrow_q, rrow_d;
   logic [1:0]            rcol_q, rcol_d;
   logic                  cap_en_q, cap_en_d;
   logic [1:0]            cap_row_q, cap_row_d;
   logic [2:0][23:0]      cache_q, cache_d;
   logic [1:0]            ks_q, ks_d;
   logic [ADDR_W-1:0]     src_q, src_d;
   logic [ADDR_W-1:0]     dst_q, dst_d;
   logic [bus-1:0]        wdata_q, wdata_d;

   logic                  reuse;
   logic [1:0]            rd_col;
   logic                  last_rd;
   logic                  last_win;
   logic [ADDR_W-1:0]     rd_off;
   logic [ADDR_W-1:0]     wr_off;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         rrow_q    <= '0;
         rcol_q    <= '0;
         cap_en_q  <= 1'b0;
         cap_row_q <= '0;
         cache_q   <= '0;
         ks_q      <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         rrow_q    <= rrow_d;
         rcol_q    <= rcol_d;
         cap_en_q  <= cap_en_d;
         cap_row_q <= cap_row_d;
         cache_q   <= cache_d;
         ks_q      <= ks_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      rrow_d    = rrow_q;
      rcol_d    = rcol_q;
      cap_en_d  = 1'b0;
      cap_row_d = cap_row_q;
      cache_d   = cache_q;
      ks_d      = ks_q;
      src_d     = src_q;
      dst_d     = dst_q;
      wdata_d   = wdata_q;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      done      = 1'b0;

      // With reuse, only the new right-hand column is read; the shift keeps the other two.
      reuse    = REUSE_EN && (x_q != 8'd1);
      rd_col   = reuse ? 2'd2 : rcol_q;
      last_rd  = (rrow_q == 2'd2) && (reuse || (rcol_q == 2'd2));
      last_win = (x_q == X_LAST) && (y_q == Y_LAST);

      if (cap_en_q) begin
         cache_d[cap_row_q] = {cache_q[cap_row_q][15:0], rd_data};
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ks_d    = kernelsel_in;
               src_d   = src_base;
               dst_d   = dst_base;
               x_d     = 8'd1;
               y_d     = 8'd1;
               rrow_d  = '0;
               rcol_d  = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            rd_en     = 1'b1;
            cap_en_d  = 1'b1;
            cap_row_d = rrow_q;
            if (last_rd) begin
               state_d = S_DRAIN;
            end else if (reuse || (rcol_q == 2'd2)) begin
               rcol_d = '0;
               rrow_d = rrow_q + 2'd1;
            end else begin
               rcol_d = rcol_q + 2'd1;
            end
         end
         S_DRAIN: state_d = S_EXEC;
         S_EXEC: begin
            wdata_d = alu_result;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            wr_en  = 1'b1;
            rrow_d = '0;
            rcol_d = '0;
            if (last_win) begin
               state_d = S_DONE;
            end else begin
               if (x_q == X_LAST) begin
                  x_d = 8'd1;
                  y_d = y_q + 8'd1;
               end else begin
                  x_d = x_q + 8'd1;
               end
               state_d = S_FETCH;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Offsets are reduced to ADDR_W bits so the base addition wraps modulo 2^ADDR_W.
      rd_off = ADDR_W'((32'(y_q) + 32'(rrow_q) - 32'd1) * 32'(IMG_W)
                       + 32'(x_q) + 32'(rd_col) - 32'd1);
      wr_off = ADDR_W'((32'(y_q) - 32'd1) * 32'(IMG_W - 2) + 32'(x_q) - 32'd1);
   end

   assign rd_addr   = rd_en ? (src_q + rd_off) : '0;
   assign wr_addr   = wr_en ? (dst_q + wr_off) : '0;
   assign wr_data   = wdata_q;
   assign cache     = cache_q;
   assign kernelsel = ks_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                      (state_q == S_EXEC)  || (state_q == S_WRITE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_kernel_sequencer.sv
// Directed-plus-random bench for kernel_sequencer on a 4x4 image with a behavioural RAM
// and ALU beside the DUT; expected writes, reads and windows come from a pixel-level model.
module tb_kernel_sequencer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        kernelsel_in = '0;
  logic [AW-1:0]     src_base = '0;
  logic [AW-1:0]     dst_base = '0;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [7:0]        rd_data = '0;
  logic [2:0][23:0]  cache;
  logic [1:0]        kernelsel;
  logic [7:0]        alu_result;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  kernel_sequencer #(.bus(8), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .kernelsel_in(kernelsel_in),
    .src_base(src_base), .dst_base(dst_base), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .cache(cache), .kernelsel(kernelsel), .alu_result(alu_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural RAM and ALU
  logic [7:0] mem [0:65535];
  logic       alu_mode = 1'b0;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  assign alu_result = alu_mode
    ? ((cache[0][23:16] + {cache[1][14:8], 1'b0} + cache[2][7:0]) ^ {6'b0, kernelsel})
    : cache[1][15:8];

  // monitor
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [7:0]    wd_q[$];
  logic [71:0]   wc_q[$];
  int            busy_cnt, done_cnt, ks_bad;
  logic [1:0]    mon_ks;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (busy && kernelsel !== mon_ks) ks_bad++;
    if (rd_en) rd_q.push_back(rd_addr);
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cache);
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete();
    busy_cnt = 0; done_cnt = 0; ks_bad = 0;
  endtask

  function automatic logic [7:0] pix(input logic [AW-1:0] src, input int r, input int c);
    logic [AW-1:0] a;
    a = src + AW'(r * W + c);
    return mem[a];
  endfunction

  function automatic logic [71:0] exp_win(input logic [AW-1:0] src, input int y, input int x);
    logic [71:0] v;
    v = '0;
    for (int r = 0; r < 3; r++)
      v[r*24 +: 24] = {pix(src, y-1+r, x-1), pix(src, y-1+r, x), pix(src, y-1+r, x+1)};
    return v;
  endfunction

  function automatic logic [7:0] exp_alu(input logic [AW-1:0] src, input int y, input int x,
                                         input logic [1:0] ks);
    logic [7:0] s;
    if (!alu_mode) return pix(src, y, x);
    s = pix(src, y-1, x-1) + 8'(2 * pix(src, y, x)) + pix(src, y+1, x+1);
    return s ^ {6'b0, ks};
  endfunction

  function automatic bit reuse_build();
`ifdef KSEQ_SLIDE_REUSE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_image(input logic [AW-1:0] src);
    logic [AW-1:0] a;
    for (int i = 0; i < W*H; i++) begin
      a = src + AW'(i);
      mem[a] = 8'($urandom_range(0, 255));
    end
  endtask

  // driver tasks
  task automatic start_pass(input logic [1:0] ks, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst);
    @(posedge clk); #1;
    clear_mon();
    mon_ks = ks;
    @(negedge clk);
    kernelsel_in = ks; src_base = src; dst_base = dst; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cnt != 0) break;
    end
    if (i == budget) chk({tag, "_timeout"}, 72'(done_cnt), 72'd1);
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic check_pass(input string tag, input logic [AW-1:0] src,
                            input logic [AW-1:0] dst, input logic [1:0] ks);
    logic [AW-1:0] exp_rd[$];
    int k, exp_busy;
    exp_rd.delete();
    for (int y = 1; y <= H-2; y++)
      for (int x = 1; x <= W-2; x++)
        if (reuse_build() && x > 1)
          for (int r = -1; r <= 1; r++) exp_rd.push_back(src + AW'((y+r)*W + x+1));
        else
          for (int r = -1; r <= 1; r++)
            for (int c = -1; c <= 1; c++) exp_rd.push_back(src + AW'((y+r)*W + x+c));
    exp_busy = reuse_build() ? (H-2) * (12 + 6*(W-3)) : (H-2) * 12 * (W-2);

    chk({tag, "_done_pulses"}, 72'(done_cnt), 72'd1);
    chk({tag, "_busy_cycles"}, 72'(busy_cnt), 72'(exp_busy));
    chk({tag, "_ks_held"}, 72'(ks_bad), 72'd0);
    chk({tag, "_rd_count"}, 72'(rd_q.size()), 72'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      chk($sformatf("%s_rd_addr%0d", tag, i), 72'(rd_q[i]), 72'(exp_rd[i]));
    chk({tag, "_wr_count"}, 72'(wa_q.size()), 72'((W-2)*(H-2)));
    k = 0;
    for (int y = 1; y <= H-2; y++)
      for (int x = 1; x <= W-2; x++) begin
        if (k < wa_q.size()) begin
          chk($sformatf("%s_wr_addr%0d", tag, k), 72'(wa_q[k]), 72'(dst + AW'(k)));
          chk($sformatf("%s_wr_data%0d", tag, k), 72'(wd_q[k]), 72'(exp_alu(src, y, x, ks)));
          chk($sformatf("%s_cache%0d", tag, k), wc_q[k], exp_win(src, y, x));
        end
        k++;
      end
  endtask

  initial begin
    logic [AW-1:0] src, dst;
    logic [1:0]    ks;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mon_ks = '0;

    // reset and idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_done", 72'(done), 72'd0);
    chk("rst_rd_en", 72'(rd_en), 72'd0);
    chk("rst_wr_en", 72'(wr_en), 72'd0);
    chk("rst_rd_addr", 72'(rd_addr), 72'd0);
    chk("rst_wr_addr", 72'(wr_addr), 72'd0);
    chk("rst_wr_data", 72'(wr_data), 72'd0);
    chk("rst_kernelsel", 72'(kernelsel), 72'd0);
    chk("rst_cache", 72'(cache), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (20) @(posedge clk);
    #2;
    chk("idle_rd_cnt", 72'(rd_q.size()), 72'd0);
    chk("idle_wr_cnt", 72'(wa_q.size()), 72'd0);
    chk("idle_busy", 72'(busy_cnt), 72'd0);

    // basic pass with the counting image
    for (int i = 0; i < W*H; i++) mem[16'h0100 + i] = 8'(i);
    alu_mode = 1'b0;
    start_pass(2'b00, 16'h0100, 16'h0200);
    wait_done("basic", 200);
    check_pass("basic", 16'h0100, 16'h0200, 2'b00);
    if (wd_q.size() == 4) begin
      chk("basic_w0", 72'(wd_q[0]), 72'd5);
      chk("basic_w3", 72'(wd_q[3]), 72'd10);
    end else chk("basic_w_size", 72'(wd_q.size()), 72'd4);
    if (wc_q.size() > 0) chk("pack_win11", wc_q[0], {24'h08090A, 24'h040506, 24'h000102});
    if (rd_q.size() > 0) chk("basic_first_rd", 72'(rd_q[0]), 72'h0100);

    // kernel latch with mid-pass disturbance
    alu_mode = 1'b1;
    src = 16'(($urandom_range(0, 255)) << 8);
    dst = 16'($urandom_range(0, 65535));
    fill_image(src);
    start_pass(2'b11, src, dst);
    repeat (15) @(negedge clk);
    kernelsel_in = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("latch", 200);
    check_pass("latch", src, dst, 2'b11);

    // address wrap on the source side
    fill_image(16'hFFFE);
    dst = 16'($urandom_range(0, 65535));
    start_pass(2'b10, 16'hFFFE, dst);
    wait_done("wrap", 200);
    if (rd_q.size() > 2) begin
      chk("wrap_rd1", 72'(rd_q[1]), 72'hFFFF);
      chk("wrap_rd2", 72'(rd_q[2]), 72'h0000);
    end else chk("wrap_rd_size", 72'(rd_q.size()), 72'd9);
    check_pass("wrap", 16'hFFFE, dst, 2'b10);

    // randomized passes
    for (int p = 0; p < 4; p++) begin
      alu_mode = 1'($urandom_range(0, 1));
      src = 16'($urandom_range(0, 65535));
      dst = 16'($urandom_range(0, 65535));
      ks  = 2'($urandom_range(0, 3));
      fill_image(src);
      start_pass(ks, src, dst);
      wait_done($sformatf("rand%0d", p), 200);
      check_pass($sformatf("rand%0d", p), src, dst, ks);
    end

    // reset during the second fetch
    alu_mode = 1'b0;
    src = 16'h3000;
    dst = 16'h4000;
    fill_image(src);
    start_pass(2'b01, src, dst);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rd_q.size() >= 10) break;
    end
    chk("mid_reached_fetch2", 72'(rd_q.size()), 72'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy_after_rst", 72'(busy), 72'd0);
    chk("mid_rd_en_after_rst", 72'(rd_en), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("mid_rd_total", 72'(rd_q.size()), 72'd10);
    chk("mid_wr_total", 72'(wa_q.size()), 72'd1);
    chk("mid_no_done", 72'(done_cnt), 72'd0);
    start_pass(2'b10, src, dst);
    wait_done("restart", 200);
    check_pass("restart", src, dst, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
